stage_mem: RTL and testbench

- Memory stage of the in-order RV64 pipeline, directly downstream of the execute stage.
- Latches one execute result (ALU result, effective address, store data, funct3, destination register) and runs the data-cache transaction for loads and stores.
- Aligns and sign/zero-extends load data, builds store byte strobes, detects misalignment, and presents a registered result to write-back over a valid/ready handshake.
- Single-entry stage; it is never bypassed.

---
 rtl/stage_mem.sv | 218 +++++++++++++++++++++
 tb/tb_stage_mem.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_mem.sv
// Memory stage: latches one execute result, runs the data-cache access,
// aligns load data and hands a registered result to write-back.
module stage_mem #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_alu_out,
  input  logic [XLEN-1:0] in_memaddr,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [2:0]      in_funct3,
  input  logic            in_mem_read,
  input  logic            in_mem_write,
  input  logic [4:0]      in_rd,
  input  logic            in_reg_write,
  output logic            dc_req,
  output logic            dc_we,
  output logic [XLEN-1:0] dc_addr,
  output logic [XLEN-1:0] dc_wdata,
  output logic [7:0]      dc_wstrb,
  input  logic            dc_req_ready,
  input  logic            dc_resp_valid,
  input  logic [XLEN-1:0] dc_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic [XLEN-1:0] out_wb_data,
  output logic            out_misalign,
  output logic [XLEN-1:0] out_badaddr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] wb_q, wb_d;
  logic [XLEN-1:0] bad_q, bad_d;
  logic [7:0]      wstrb_q, wstrb_d;
  logic [4:0]      rd_q, rd_d;
  logic [2:0]      f3_q, f3_d;
  logic            rw_q, rw_d;
  logic            we_q, we_d;
  logic            mis_q, mis_d;

  logic            accept;
  logic            mem_op;
  logic            mis_in;
  logic [7:0]      size_mask;
  logic [2:0]      off_in;

  function automatic logic [XLEN-1:0] extract(
    input logic [2:0]      f3,
    input logic [2:0]      off,
    input logic [XLEN-1:0] d
  );
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] r;
    sh = d >> {off, 3'b000};
    case (f3)
      3'b000:  r = {{56{sh[7]}}, sh[7:0]};
      3'b100:  r = {56'd0, sh[7:0]};
      3'b001:  r = {{48{sh[15]}}, sh[15:0]};
      3'b101:  r = {48'd0, sh[15:0]};
      3'b010:  r = {{32{sh[31]}}, sh[31:0]};
      3'b110:  r = {32'd0, sh[31:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  assign off_in = in_memaddr[2:0];
  assign mem_op = in_mem_read || in_mem_write;

  always_comb begin
    mis_in    = 1'b0;
    size_mask = 8'h01;
    unique case (1'b1)
      in_funct3[1:0] == 2'b01: begin
        mis_in    = in_memaddr[0];
        size_mask = 8'h03;
      end
      in_funct3[1:0] == 2'b10: begin
        mis_in    = |in_memaddr[1:0];
        size_mask = 8'h0F;
      end
      in_funct3[1:0] == 2'b11: begin
        mis_in    = |in_memaddr[2:0];
        size_mask = 8'hFF;
      end
      default: ;
    endcase
  end

  assign in_ready = !mem_flush &&
    (state_q == S_IDLE || (state_q == S_HOLD && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wb_d    = wb_q;
    bad_d   = bad_q;
    wstrb_d = wstrb_q;
    rd_d    = rd_q;
    f3_d    = f3_q;
    rw_d    = rw_q;
    we_d    = we_q;
    mis_d   = mis_q;
    if (mem_flush) begin
      // An outstanding cache access must still be drained.
      case (state_q)
        S_WAIT, S_DRAIN:
          state_d = dc_resp_valid ? S_IDLE : S_DRAIN;
        default:
          state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_ISSUE:
          if (dc_req_ready) state_d = S_WAIT;
        S_WAIT:
          if (dc_resp_valid) begin
            state_d = S_HOLD;
            if (we_q) rw_d = 1'b0;
            else wb_d = extract(f3_q, addr_q[2:0], dc_rdata);
          end
        S_DRAIN:
          if (dc_resp_valid) state_d = S_IDLE;
        S_HOLD:
          if (out_ready) state_d = S_IDLE;
        default: ;
      endcase
      if (accept) begin
        pc_d    = in_pc;
        rd_d    = in_rd;
        rw_d    = in_reg_write;
        addr_d  = in_memaddr;
        f3_d    = in_funct3;
        we_d    = in_mem_write;
        wstrb_d = size_mask << off_in;
        wdata_d = in_rs2 << {off_in, 3'b000};
        wb_d    = in_alu_out;
        mis_d   = 1'b0;
        bad_d   = '0;
        if (!mem_op) begin
          state_d = S_HOLD;
        end else if (mis_in) begin
          state_d = S_HOLD;
          mis_d   = 1'b1;
          bad_d   = in_memaddr;
          rw_d    = 1'b0;
        end else begin
          state_d = S_ISSUE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wb_q    <= '0;
      bad_q   <= '0;
      wstrb_q <= '0;
      rd_q    <= '0;
      f3_q    <= '0;
      rw_q    <= 1'b0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wb_q    <= wb_d;
      bad_q   <= bad_d;
      wstrb_q <= wstrb_d;
      rd_q    <= rd_d;
      f3_q    <= f3_d;
      rw_q    <= rw_d;
      we_q    <= we_d;
      mis_q   <= mis_d;
    end
  end

  assign dc_req        = (state_q == S_ISSUE);
  assign dc_we         = we_q;
  assign dc_addr       = {addr_q[XLEN-1:3], 3'b000};
  assign dc_wdata      = wdata_q;
  assign dc_wstrb      = wstrb_q;
  assign out_valid     = (state_q == S_HOLD);
  assign out_pc        = pc_q;
  assign out_rd        = rd_q;
  assign out_reg_write = rw_q;
  assign out_wb_data   = wb_q;
  assign out_misalign  = mis_q;
  assign out_badaddr   = bad_q;

endmodule

// File: tb/tb_stage_mem.sv
// Bench for stage_mem: directed scenarios plus random traffic checked
// against a transaction-level model of the stage and its cache.
module tb_stage_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc, in_alu_out, in_memaddr, in_rs2;
  logic [2:0]  in_funct3;
  logic        in_mem_read, in_mem_write;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        dc_req, dc_we;
  logic [63:0] dc_addr, dc_wdata;
  logic [7:0]  dc_wstrb;
  logic        dc_req_ready, dc_resp_valid;
  logic [63:0] dc_rdata;
  logic        out_valid, out_ready;
  logic [63:0] out_pc;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic [63:0] out_wb_data;
  logic        out_misalign;
  logic [63:0] out_badaddr;

  always #5 clk = ~clk;

  stage_mem #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .mem_flush(mem_flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_alu_out(in_alu_out),
    .in_memaddr(in_memaddr), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_rd(in_rd),
    .in_reg_write(in_reg_write),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr),
    .dc_wdata(dc_wdata), .dc_wstrb(dc_wstrb),
    .dc_req_ready(dc_req_ready), .dc_resp_valid(dc_resp_valid),
    .dc_rdata(dc_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_wb_data(out_wb_data),
    .out_misalign(out_misalign), .out_badaddr(out_badaddr)
  );

  int n_chk = 0;
  int n_err = 0;

  // Model: what the stage holds, and where that item is in its life.
  bit          m_occ, m_req, m_wait, m_drop, m_done;
  logic [63:0] m_pc, m_wb, m_bad, m_addr, m_wdata;
  logic [7:0]  m_wstrb;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic        m_we, m_rw, m_mis;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_load(input logic [2:0] f3,
      input logic [63:0] addr, input logic [63:0] d);
    int sz;
    logic [63:0] v, mask;
    sz = 1 << f3[1:0];
    v = d >> (8 * addr[2:0]);
    if (sz == 8) return v;
    mask = (64'd1 << (8 * sz)) - 64'd1;
    v = v & mask;
    if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic model_clear();
    m_occ = 0; m_req = 0; m_wait = 0; m_drop = 0; m_done = 0;
  endtask

  task automatic model_accept();
    int sz;
    logic [63:0] m8;
    sz = 1 << in_funct3[1:0];
    m_occ = 1; m_req = 0; m_wait = 0; m_drop = 0; m_done = 0;
    m_pc = in_pc; m_rd = in_rd; m_rw = in_reg_write;
    m_wb = in_alu_out; m_mis = 0; m_bad = 0;
    m_addr = in_memaddr; m_f3 = in_funct3; m_we = in_mem_write;
    m8 = (64'd1 << sz) - 64'd1;
    m_wstrb = 8'(m8 << in_memaddr[2:0]);
    m_wdata = in_rs2 << (8 * in_memaddr[2:0]);
    if (!(in_mem_read || in_mem_write)) begin
      m_done = 1;
    end else if ((in_memaddr % 64'(sz)) != 0) begin
      m_done = 1; m_mis = 1; m_bad = in_memaddr; m_rw = 0;
    end else begin
      m_req = 1;
    end
  endtask

  // Compare all outputs against the model, then advance one clock.
  task automatic tick();
    bit exp_ir, acc;
    #1;
    exp_ir = !mem_flush && (!m_occ || (m_done && out_ready));
    chk("in_ready", 64'(in_ready), 64'(exp_ir));
    chk("dc_req", 64'(dc_req), 64'(m_req));
    if (m_req) begin
      chk("dc_addr", dc_addr, {m_addr[63:3], 3'b000});
      chk("dc_we", 64'(dc_we), 64'(m_we));
      chk("dc_wstrb", 64'(dc_wstrb), 64'(m_wstrb));
      if (m_we) chk("dc_wdata", dc_wdata, m_wdata);
    end
    chk("out_valid", 64'(out_valid), 64'(m_done));
    if (m_done) begin
      chk("out_pc", out_pc, m_pc);
      chk("out_rd", 64'(out_rd), 64'(m_rd));
      chk("out_reg_write", 64'(out_reg_write), 64'(m_rw));
      chk("out_misalign", 64'(out_misalign), 64'(m_mis));
      chk("out_badaddr", out_badaddr, m_bad);
      if (!m_mis && !m_we) chk("out_wb_data", out_wb_data, m_wb);
    end
    acc = in_valid && exp_ir;
    if (mem_flush) begin
      if ((m_wait || m_drop) && !dc_resp_valid) begin
        model_clear(); m_occ = 1; m_drop = 1;
      end else begin
        model_clear();
      end
    end else begin
      if (m_req && dc_req_ready) begin
        m_req = 0; m_wait = 1;
      end else if (m_wait && dc_resp_valid) begin
        m_wait = 0; m_done = 1;
        if (m_we) m_rw = 0;
        else m_wb = ref_load(m_f3, m_addr, dc_rdata);
      end else if (m_drop && dc_resp_valid) begin
        model_clear();
      end else if (m_done && out_ready) begin
        model_clear();
      end
      if (acc) model_accept();
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet();
    mem_flush = 0; in_valid = 0; in_mem_read = 0; in_mem_write = 0;
    dc_req_ready = 0; dc_resp_valid = 0;
  endtask

  task automatic drive(input logic rd_, input logic wr_,
      input logic [2:0] f3, input logic [63:0] addr,
      input logic [63:0] rs2, input logic [63:0] alu);
    in_valid = 1; in_mem_read = rd_; in_mem_write = wr_;
    in_funct3 = f3; in_memaddr = addr; in_rs2 = rs2; in_alu_out = alu;
    in_pc = in_pc + 64'd4; in_rd = in_rd + 5'd1; in_reg_write = 1;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [63:0] addr,
      input logic [63:0] data, input logic [63:0] exp);
    out_ready = 1;
    drive(1, 0, f3, addr, 0, 64'hDEAD);
    tick();
    in_valid = 0;
    chk("ld_dc_req", 64'(dc_req), 64'd1);
    chk("ld_dc_addr", dc_addr, {addr[63:3], 3'b000});
    dc_req_ready = 1; tick(); dc_req_ready = 0;
    dc_resp_valid = 1; dc_rdata = data; tick(); dc_resp_valid = 0;
    chk("ld_valid", 64'(out_valid), 64'd1);
    chk("ld_data", out_wb_data, exp);
    tick();
  endtask

  initial begin
    rst = 1; quiet(); out_ready = 0;
    in_pc = 0; in_alu_out = 0; in_memaddr = 0; in_rs2 = 0;
    in_funct3 = 0; in_rd = 0; in_reg_write = 0; dc_rdata = 0;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_dc_req", 64'(dc_req), 64'd0);
    chk("rst_wb_data", out_wb_data, 64'd0);
    chk("rst_badaddr", out_badaddr, 64'd0);

    // ALU pass-through, one cycle latency
    out_ready = 1;
    drive(0, 0, 3'd0, 64'h0, 64'h0, 64'h1234);
    tick(); in_valid = 0;
    chk("alu_valid", 64'(out_valid), 64'd1);
    chk("alu_data", out_wb_data, 64'h1234);
    chk("alu_no_req", 64'(dc_req), 64'd0);
    tick();

    do_load(3'b000, 64'h1003, 64'h0000_0000_8000_0000,
            64'hFFFF_FFFF_FFFF_FF80);
    do_load(3'b100, 64'h1003, 64'h0000_0000_8000_0000, 64'h80);

    // sh with a slow cache
    drive(0, 1, 3'b001, 64'h2006, 64'hABCD, 64'h0);
    tick(); in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("sh_req", 64'(dc_req), 64'd1);
      chk("sh_wstrb", 64'(dc_wstrb), 64'hC0);
      chk("sh_wdata", dc_wdata, 64'hABCD_0000_0000_0000);
      dc_req_ready = (i == 3);
      tick();
    end
    dc_req_ready = 0;
    chk("sh_req_drop", 64'(dc_req), 64'd0);
    dc_resp_valid = 1; tick(); dc_resp_valid = 0;
    chk("sh_valid", 64'(out_valid), 64'd1);
    chk("sh_rw", 64'(out_reg_write), 64'd0);
    tick();

    // misaligned lw
    drive(1, 0, 3'b010, 64'h3002, 0, 0);
    tick(); in_valid = 0;
    chk("mis_flag", 64'(out_misalign), 64'd1);
    chk("mis_bad", out_badaddr, 64'h3002);
    chk("mis_rw", 64'(out_reg_write), 64'd0);
    chk("mis_req", 64'(dc_req), 64'd0);
    tick();

    // flush while waiting on ld
    drive(1, 0, 3'b011, 64'h4000, 0, 0);
    tick(); in_valid = 0;
    dc_req_ready = 1; tick(); dc_req_ready = 0;
    mem_flush = 1; tick(); mem_flush = 0;
    chk("drain_valid", 64'(out_valid), 64'd0);
    tick();
    dc_resp_valid = 1; dc_rdata = 64'h5555; tick(); dc_resp_valid = 0;
    #1 chk("drain_ready", 64'(in_ready), 64'd1);
    chk("drain_valid2", 64'(out_valid), 64'd0);
    drive(0, 0, 3'd0, 0, 0, 64'h77);
    tick(); in_valid = 0;
    chk("post_drain_data", out_wb_data, 64'h77);
    tick();

    // stall then back-to-back accept
    out_ready = 0;
    drive(0, 0, 3'd0, 0, 0, 64'h44);
    tick(); in_valid = 0;
    repeat (5) tick();
    out_ready = 1;
    drive(0, 0, 3'd0, 0, 0, 64'h55);
    tick(); in_valid = 0;
    chk("b2b_valid", 64'(out_valid), 64'd1);
    chk("b2b_data", out_wb_data, 64'h55);
    tick();

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      int kind;
      int sz;
      mem_flush = ($urandom % 12) == 0;
      in_valid = ($urandom % 10) < 7;
      kind = $urandom % 3;
      in_mem_read = (kind == 1);
      in_mem_write = (kind == 2);
      in_funct3 = 3'($urandom);
      if (in_mem_write) in_funct3[2] = 1'b0;
      sz = 1 << in_funct3[1:0];
      in_memaddr = {$urandom, $urandom};
      case ($urandom % 3)
        0: ;
        1: in_memaddr[2:0] = 3'd0;
        default: in_memaddr = in_memaddr & ~(64'(sz) - 64'd1);
      endcase
      in_rs2 = {$urandom, $urandom};
      in_alu_out = {$urandom, $urandom};
      in_pc = {$urandom, $urandom};
      in_rd = 5'($urandom);
      in_reg_write = 1'($urandom);
      out_ready = ($urandom % 10) < 6;
      dc_req_ready = m_req && !mem_flush && (($urandom % 3) == 0);
      dc_resp_valid = (m_wait || m_drop) && (($urandom % 3) == 0);
      dc_rdata = {$urandom, $urandom};
      tick();
    end

    // reset in the middle of an outstanding access
    quiet(); out_ready = 1;
    drive(1, 0, 3'b011, 64'h8000, 0, 0);
    tick(); in_valid = 0;
    dc_req_ready = 1; tick(); dc_req_ready = 0;
    rst = 1;
    @(posedge clk); @(negedge clk);
    rst = 0; model_clear();
    #1;
    chk("rst2_in_ready", 64'(in_ready), 64'd1);
    chk("rst2_out_valid", 64'(out_valid), 64'd0);
    chk("rst2_dc_addr", dc_addr, 64'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
